// File: rtl/fp_add_align_pipe_pkg.sv
// Shared types and width helpers for the floating-point adder pipeline.
// The operand struct below is sized for the default single-precision format.
package fp_add_pkg;

  localparam int GRS_WIDTH      = 3;
  localparam int DEF_EXPO_WIDTH = 8;
  localparam int DEF_MENT_WIDTH = 23;
  localparam int SHIFT_WIDTH    = DEF_EXPO_WIDTH + 1;
  localparam int ALIGN_WIDTH    = DEF_MENT_WIDTH + 1 + GRS_WIDTH;

  function automatic int shift_width(input int expo_width);
    return expo_width + 1;
  endfunction

  function automatic int align_width(input int ment_width);
    return ment_width + 1 + GRS_WIDTH;
  endfunction

  typedef struct packed {
    logic                      sign;
    logic [DEF_EXPO_WIDTH-1:0] eff_exp;
    logic [DEF_MENT_WIDTH:0]   mant_with_hidden;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_add_align_pipe_if.sv
// Operand/result handshake bundle between the adder front end and its neighbours.
interface fp_add_align_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int EXPO_WIDTH = 8,
  parameter int MENT_WIDTH = 23
);
  logic [DATA_WIDTH-1:0] floating1_in;
  logic [DATA_WIDTH-1:0] floating2_in;
  logic                  in_valid_in;
  logic                  in_ready_out;
  logic                  out_ready_in;
  logic                  out_valid_out;
  logic [MENT_WIDTH:0]   bigger_mant_out;
  logic [MENT_WIDTH+3:0] aligned_mant_out;
  logic [EXPO_WIDTH-1:0] bigger_exponent_out;
  logic                  sign_out;
  logic                  eff_sub_out;
  logic                  swap_out;
  logic                  special_out;

  modport slave (
    input  floating1_in, floating2_in, in_valid_in, out_ready_in,
    output in_ready_out, out_valid_out, bigger_mant_out, aligned_mant_out,
           bigger_exponent_out, sign_out, eff_sub_out, swap_out, special_out
  );

  modport master (
    output floating1_in, floating2_in, in_valid_in, out_ready_in,
    input  in_ready_out, out_valid_out, bigger_mant_out, aligned_mant_out,
           bigger_exponent_out, sign_out, eff_sub_out, swap_out, special_out
  );
endinterface

// File: rtl/fp_align_shifter.sv
// Combinational right shifter that appends G/R/S bits, folds shifted-out bits
// into the sticky LSB and saturates to a lone sticky bit for oversized shifts.
module fp_align_shifter
  import fp_add_pkg::*;
#(
  parameter int MANT_WIDTH  = 24,
  parameter int SHIFT_WIDTH = 9
) (
  input  logic [MANT_WIDTH-1:0]           mant,
  input  logic [SHIFT_WIDTH-1:0]          shift,
  output logic [MANT_WIDTH+GRS_WIDTH-1:0] aligned
);
  localparam int AW = MANT_WIDTH + GRS_WIDTH;

  function automatic logic [AW-1:0] sticky_shift(input logic [MANT_WIDTH-1:0]  m,
                                                 input logic [SHIFT_WIDTH-1:0] s);
    logic [AW-1:0] ext;
    logic [AW-1:0] lost_mask;
    ext = {m, {GRS_WIDTH{1'b0}}};
    if (s >= SHIFT_WIDTH'(AW)) begin
      return {{(AW-1){1'b0}}, |m};
    end
    lost_mask = ~({AW{1'b1}} << s);
    return (ext >> s) | {{(AW-1){1'b0}}, |(ext & lost_mask)};
  endfunction

  assign aligned = sticky_shift(mant, shift);
endmodule

// File: rtl/fp_add_align_pipe.sv
// Two-stage alignment front end: unpack and order operands by magnitude, then
// shift the smaller mantissa into place with guard/round/sticky bits.
module fp_add_align_pipe
  import fp_add_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int EXPO_WIDTH = 8,
  parameter int MENT_WIDTH = 23
) (
  input logic                clk_in,
  input logic                rst_n_in,
  fp_add_align_pipe_if.slave bus
);
  localparam int SHIFT_W = shift_width(EXPO_WIDTH);
  localparam int ALIGN_W = align_width(MENT_WIDTH);

  logic                  sign_a, sign_b;
  logic [EXPO_WIDTH-1:0] exp_a, exp_b, eff_a, eff_b;
  logic [MENT_WIDTH-1:0] frac_a, frac_b;
  logic [MENT_WIDTH:0]   mant_a, mant_b;
  logic                  swap;
  logic [SHIFT_W-1:0]    diff;
  logic                  s1_load, s2_load, accept;

  logic                  vld_p1, vld_p2;
  logic [MENT_WIDTH:0]   big_mant_p1, small_mant_p1, big_mant_p2;
  logic [EXPO_WIDTH-1:0] big_exp_p1, big_exp_p2;
  logic [SHIFT_W-1:0]    diff_p1;
  logic                  sign_p1, eff_sub_p1, swap_p1, special_p1;
  logic                  sign_p2, eff_sub_p2, swap_p2, special_p2;
  logic [ALIGN_W-1:0]    aligned_p1, aligned_p2;

  assign {sign_a, exp_a, frac_a} = bus.floating1_in;
  assign {sign_b, exp_b, frac_b} = bus.floating2_in;

  // Zero/denormal operands sit at effective exponent 1 with no hidden bit.
  assign eff_a  = (exp_a != '0) ? exp_a : EXPO_WIDTH'(1);
  assign eff_b  = (exp_b != '0) ? exp_b : EXPO_WIDTH'(1);
  assign mant_a = {exp_a != '0, frac_a};
  assign mant_b = {exp_b != '0, frac_b};

  assign swap = {eff_b, frac_b} > {eff_a, frac_a};
  assign diff = swap ? ({1'b0, eff_b} - {1'b0, eff_a}) : ({1'b0, eff_a} - {1'b0, eff_b});

  assign s2_load          = !vld_p2 | bus.out_ready_in;
  assign s1_load          = !vld_p1 | s2_load;
  assign accept           = bus.in_valid_in & s1_load;
  assign bus.in_ready_out = s1_load;

  // Stage 1: magnitude ordering and exponent difference
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p1        <= 1'b0;
      big_mant_p1   <= '0;
      small_mant_p1 <= '0;
      big_exp_p1    <= '0;
      diff_p1       <= '0;
      sign_p1       <= 1'b0;
      eff_sub_p1    <= 1'b0;
      swap_p1       <= 1'b0;
      special_p1    <= 1'b0;
    end else begin
      if (s1_load) vld_p1 <= bus.in_valid_in;
      if (accept) begin
        big_mant_p1   <= swap ? mant_b : mant_a;
        small_mant_p1 <= swap ? mant_a : mant_b;
        big_exp_p1    <= swap ? eff_b : eff_a;
        diff_p1       <= diff;
        sign_p1       <= swap ? sign_b : sign_a;
        eff_sub_p1    <= sign_a ^ sign_b;
        swap_p1       <= swap;
        special_p1    <= (&exp_a) | (&exp_b);
      end
    end
  end

  fp_align_shifter #(
    .MANT_WIDTH  (MENT_WIDTH + 1),
    .SHIFT_WIDTH (SHIFT_W)
  ) u_shifter (
    .mant    (small_mant_p1),
    .shift   (diff_p1),
    .aligned (aligned_p1)
  );

  // Stage 2: aligned mantissa and result registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p2      <= 1'b0;
      big_mant_p2 <= '0;
      aligned_p2  <= '0;
      big_exp_p2  <= '0;
      sign_p2     <= 1'b0;
      eff_sub_p2  <= 1'b0;
      swap_p2     <= 1'b0;
      special_p2  <= 1'b0;
    end else if (s2_load) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        big_mant_p2 <= big_mant_p1;
        aligned_p2  <= aligned_p1;
        big_exp_p2  <= big_exp_p1;
        sign_p2     <= sign_p1;
        eff_sub_p2  <= eff_sub_p1;
        swap_p2     <= swap_p1;
        special_p2  <= special_p1;
      end
    end
  end

  assign bus.out_valid_out       = vld_p2;
  assign bus.bigger_mant_out     = big_mant_p2;
  assign bus.aligned_mant_out    = aligned_p2;
  assign bus.bigger_exponent_out = big_exp_p2;
  assign bus.sign_out            = sign_p2;
  assign bus.eff_sub_out         = eff_sub_p2;
  assign bus.swap_out            = swap_p2;
  assign bus.special_out         = special_p2;
endmodule
